nonce_uplink_tx: RTL

Slave-side uplink that carries golden nonces from a miner back to a cluster hub over the async serial link. It is the transmitting end of the link whose receiving end is the hub's per-slave nonce receiver. Nonces are queued in a small FIFO, so bursts of hits are not lost while a word is on the wire. Each nonce is sent as four 8N1 UART frames, least-significant byte first.

---
 rtl/nonce_uplink_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/nonce_uplink_tx.sv
// nonce_uplink_tx: queues golden nonces in a small FIFO and sends each one
// over an 8N1 serial line as four frames, least-significant byte first.
// Consecutive words are sent back to back with no idle time between them.
module nonce_uplink_tx #(
  parameter int BAUD_DIV  = 868,
  parameter int FIFO_LOG2 = 2
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic [31:0]          nonce_in,
  input  logic                 nonce_valid,
  output logic                 TxD,
  output logic                 busy,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic                 overflow,
  output logic                 overflow_sticky
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  // A divider of 1 still needs a 1-bit timer so the terminal-count compare is legal.
  localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TW-1:0]        TIMER_LAST = TW'(BAUD_DIV - 1);
  localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_reg, state_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [31:0]          shift_reg, shift_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [1:0]           byte_idx_reg, byte_idx_next;

  logic [31:0]          fifo_mem [DEPTH];
  logic [FIFO_LOG2-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [FIFO_LOG2:0]   count_reg;
  logic                 sticky_reg;

  logic                 pop;
  logic                 push;
  logic                 full;
  logic                 tick;

  // A full FIFO can still accept a word in the cycle the FSM takes the head.
  assign full            = (count_reg == FULL_COUNT);
  assign push            = nonce_valid && !reset && (!full || pop);
  assign overflow        = nonce_valid && !reset && full && !pop;
  assign tick            = (timer_reg == TIMER_LAST);
  assign busy            = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count      = count_reg;
  assign overflow_sticky = sticky_reg;

  // Storage array: written on push only, no reset needed for the data itself.
  always_ff @(posedge hash_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= nonce_in;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      sticky_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (overflow) begin
        sticky_reg <= 1'b1;
      end
    end
  end

  // Transmitter state, bit timer, shift register and frame indices.
  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      shift_reg    <= shift_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
    end
  end

  // Next-state, line level and FIFO pop; each line state lasts one full bit period.
  always_comb begin
    state_next    = state_reg;
    timer_next    = tick ? '0 : timer_reg + 1'b1;
    shift_next    = shift_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    pop           = 1'b0;
    TxD           = 1'b1;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (count_reg != '0) begin
          pop           = 1'b1;
          shift_next    = fifo_mem[rd_ptr_reg];
          byte_idx_next = '0;
          state_next    = START;
        end
      end
      START: begin
        TxD = 1'b0;
        if (tick) begin
          bit_idx_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        TxD = shift_reg[0];
        if (tick) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      STOP: begin
        TxD = 1'b1;
        if (tick) begin
          if (byte_idx_reg != 2'd3) begin
            byte_idx_next = byte_idx_reg + 1'b1;
            state_next    = START;
          end else if (count_reg != '0) begin
            // Chain straight into the next word so the line never idles.
            pop           = 1'b1;
            shift_next    = fifo_mem[rd_ptr_reg];
            byte_idx_next = '0;
            state_next    = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
